// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the generic pipeline stage register.
//   state_t      : stage fill state; its encoding is also the occupancy count
//   OCC_W        : width of the occupancy output
//   STALL_CNT_W  : width of the optional backpressure stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int OCC_W       = 2;
  localparam int STALL_CNT_W = 32;

  // The encoding equals the number of held entries.
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. Replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB
// registers; the instantiating stage wrapper packs its fields into ctrl/data.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream presents an entry
//   in_ready   : stage can accept (registered, no path from out_ready)
//   in_ctrl    : upstream control bundle
//   in_data    : upstream payload
//   flush      : discard held entries and any inbound transfer this cycle
//   out_valid  : stage presents an entry
//   out_ready  : downstream accepts this cycle
//   out_ctrl   : control bundle, BUBBLE_CTRL whenever out_valid is low
//   out_data   : payload, holds its last value while out_valid is low
//   occupancy  : number of held entries (0, 1 or 2)
//   stall_cnt  : saturating count of cycles with out_valid=1, out_ready=0
//                (present only when PIPE_STAGE_PERF_EN is defined)
//
// Optional feature macro: PIPE_STAGE_PERF_EN
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [OCC_W-1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                accept, drain;
  logic                load_main_in, load_main_skid, load_skid;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next-state and register-load decisions.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush wins: a same-cycle drain still completes downstream, but any
      // inbound entry is dropped along with everything held.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so no accept can coincide with the drain.
          if (drain) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the payload registers are reset too (not left as don't-care) so
  // out_data and the skid contents read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready    <= 1'b1;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q  <= state_d;
      // Registered from next state so out_ready never reaches in_ready
      // combinationally.
      in_ready <= (state_d != ST_TWO);
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : BUBBLE_CTRL;
  assign out_data  = main_data_q;
  assign occupancy = OCC_W'(state_q);

`ifdef PIPE_STAGE_PERF_EN
  // Backpressure counter; saturates and is cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
